mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and sequencer for the CPU's single external memory interface. It shares the 20-bit paged memory bus between the instruction-fetch unit (read-only, 32-bit) and the load/store data path (16-bit read/write). It also runs the command/acknowledge/ready handshake toward the memory controller. It replaces the ad-hoc `fetch_addr_mux` steering with explicit grant, ownership and timeout handling.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum cycles to wait for `mem_cack` or `mem_ready` before aborting; 0 disables the timeout.
- `TO_W`, default 8: width of the timeout counter; must satisfy `TIMEOUT` < 2^`TO_W`.

Ports:
- Clocking and reset (already decided): single clock `clk`; reset `rst` is synchronous and active-high.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `f_req` in 1: fetch request.
- `f_addr` in 20: fetch address (paged).
- `f_ack` out 1: fetch command accepted (pulse).
- `f_rvalid` out 1: fetch data valid (pulse).
- `f_rdata` out 32: fetch data.
- `d_req` in 1: data request.
- `d_we` in 1: data write enable.
- `d_addr` in 20: data address.
- `d_wdata` in 16: data write value.
- `d_ack` out 1: data command accepted (pulse).
- `d_rvalid` out 1: data read valid, or write complete (pulse).
- `d_rdata` out 16: data read value.
- `err` out 1: timeout abort (pulse); attributed to the current owner.
- `mem_addr` out 20: address to the memory controller.
- `mem_wdata` out 16: write data to the memory controller.
- `mem_read` out 1: read command strobe.
- `mem_write` out 1: write command strobe.
- `mem_instr` out 1: high while the owner is fetch.
- `mem_busy` in 1: memory controller busy; no new command may start.
- `mem_cack` in 1: command accepted.
- `mem_ready` in 1: read data valid.
- `mem_rdata` in 32: read data; data port uses `[15:0]`.

## Operation
- FSM states:
  - `IDLE`: no owner.
  - `CMD`: strobe asserted, waiting for `mem_cack`.
  - `RDW`: read accepted, waiting for `mem_ready`.
  - `DONE`: one-cycle completion pulse.
- `IDLE` behaviour:
  - If any request is pending and `mem_busy` is low, pick a winner.
  - Register the winner's address, write data and `we` into `mem_addr`/`mem_wdata`/op.
  - Pulse the winner's `x_ack`, then go to `CMD`.
  - If `mem_busy` is high, stay in `IDLE`; no ack is issued.
- Requesters hold `x_req` and their inputs stable until `x_ack`. Inputs are sampled only on the ack cycle.
- Winner selection:
  - Round-robin between the two ports, tracked by a `last` bit.
  - When both ports request, the port not served last wins.
  - `last` resets to fetch, so data wins the first tie.
- `CMD` behaviour:
  - `mem_read` or `mem_write` is held high, together with `mem_instr`.
  - When `mem_cack` is seen, the strobe drops on the next edge.
  - A write then goes to `DONE`.
  - A read goes to `RDW`, or directly to `DONE` if `mem_ready` arrives in the same cycle as `mem_cack`.
- `RDW` behaviour: on `mem_ready`, capture `mem_rdata` into the owner's rdata register and go to `DONE`.
- `DONE` behaviour:
  - Pulse the owner's `x_rvalid` for exactly one cycle.
  - Update `last` to the owner, then go to `IDLE`.
- Timeout:
  - The counter clears on entry to `CMD` and `RDW` and increments every cycle in those states.
  - When it reaches `TIMEOUT`, pulse `err`, drop all strobes and return to `IDLE`.
  - No `rvalid` is issued for an aborted transaction.
  - `last` is updated as if the transaction had completed.
- rdata registers hold their value until the next capture for that port.
- `mem_rdata` is ignored outside `RDW`/`CMD`.

## Timing
- Reset values: state `IDLE`; all acks, rvalids, `err`, `mem_read`, `mem_write` and `mem_instr` are 0; `mem_addr`, `mem_wdata`, `f_rdata` and `d_rdata` are 0; `last` is fetch.
- `rst` asserted mid-transaction drops the strobes on the next edge. No completion or `err` pulse is generated.
- Best-case read:
  - Cycle 0: req seen, ack.
  - Cycle 1: `CMD` with `mem_cack` and `mem_ready`.
  - Cycle 2: `DONE`, rvalid and rdata valid.
  - Request-to-rvalid latency is 2 cycles.
- Best-case write: ack in cycle 0, cack in cycle 1, `d_rvalid` in cycle 2.
- Minimum spacing is 3 cycles per transaction. The next ack can occur in the cycle after `DONE`.
- All outputs are registered. No combinational path runs from `mem_*` inputs to requester outputs.
- `x_ack` and `x_rvalid` are never asserted for both ports in the same cycle.

## Structure
- Shared package/include `cpu_mem_pkg` holds:
  - FSM state encodings (`ST_IDLE`, `ST_CMD`, `ST_RDW`, `ST_DONE`).
  - Port IDs (`PORT_F=0`, `PORT_D=1`).
  - The 20-bit physical address width constant, shared with the paging logic.
- One sub-module, `arb_rr2`: a combinational 2-way round-robin picker. Inputs are two requests and `last`; outputs are a one-hot grant plus a valid flag. The FSM, registers and timeout counter stay in `mem_arbiter`.

## Test plan
- Single fetch:
  - Stimulus: `f_req` with `f_addr=0x12340`; memory returns cack and ready in cycle 1 with `0xDEADBEEF`.
  - Required: `f_ack` in cycle 0; `mem_read=1` and `mem_instr=1` in cycle 1; `f_rvalid` with `f_rdata=0xDEADBEEF` in cycle 2.
- Data write:
  - Stimulus: `d_we=1`, `d_addr=0x00100`, `d_wdata=0xA5A5`; cack delayed 3 cycles.
  - Required: `mem_write` held for 4 cycles; `mem_wdata=0xA5A5`; `d_rvalid` one cycle after cack; `mem_instr=0`.
- Contention:
  - Stimulus: `f_req` and `d_req` held together for 4 transactions.
  - Required: grants go D, F, D, F from reset; no cycle has both acks.
- Busy hold-off:
  - Stimulus: `mem_busy=1` for 5 cycles while `d_req` is high.
  - Required: no ack and no strobe during those cycles; ack in the first cycle `mem_busy=0`.
- Timeout:
  - Stimulus: `TIMEOUT=4`; read accepted but `mem_ready` never arrives.
  - Required: `err` pulses after 4 cycles in `RDW`; no `f_rvalid`; next request is served normally.
- Reset mid-read:
  - Stimulus: `rst` asserted in `RDW`.
  - Required: state `IDLE` and all strobes and pulses 0 on the next edge; a `mem_ready` arriving after reset produces no rvalid.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the external memory arbiter and the paging logic.
// Holds the arbiter FSM state encodings, the requester port IDs and the
// physical address / data widths of the single external memory bus.
package cpu_mem_pkg;

   // Physical address width, shared with the paging logic.
   localparam int unsigned PADDR_W = 20;
   // Data-port and fetch-port data widths.
   localparam int unsigned DDATA_W = 16;
   localparam int unsigned FDATA_W = 32;

   // Requester port IDs; also the bit index of each port in a grant vector.
   localparam logic PORT_F = 1'b0;
   localparam logic PORT_D = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_RDW  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/arb_rr2.sv
// Combinational two-way round-robin picker.
// Ports:
//   req_f_i  fetch request
//   req_d_i  data request
//   last_i   port served last (PORT_F / PORT_D)
//   gnt_o    one-hot grant, bit PORT_F = fetch, bit PORT_D = data
//   valid_o  a grant is present
module arb_rr2
   import cpu_mem_pkg::*;
(
   input  logic       req_f_i,
   input  logic       req_d_i,
   input  logic       last_i,
   output logic [1:0] gnt_o,
   output logic       valid_o
);

   always_comb begin
      gnt_o = 2'b00;
      if (req_f_i && req_d_i) begin
         // Tie: the port not served last wins.
         if (last_i == PORT_F) gnt_o[PORT_D] = 1'b1;
         else                  gnt_o[PORT_F] = 1'b1;
      end else if (req_f_i) begin
         gnt_o[PORT_F] = 1'b1;
      end else if (req_d_i) begin
         gnt_o[PORT_D] = 1'b1;
      end
      valid_o = req_f_i | req_d_i;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter and sequencer for the single external memory interface.
// Shares the paged memory bus between instruction fetch (32-bit read-only)
// and the load/store path (16-bit read/write), and runs the command /
// accept / ready handshake toward the memory controller.
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   f_req_i, f_addr_i                 fetch request and address
//   f_ack_o, f_rvalid_o, f_rdata_o    fetch accept pulse, data pulse, data
//   d_req_i, d_we_i, d_addr_i,
//   d_wdata_i                         data request, write enable, addr, wdata
//   d_ack_o, d_rvalid_o, d_rdata_o    data accept pulse, done pulse, read data
//   err_o                             timeout abort pulse (current owner)
//   mem_addr_o, mem_wdata_o           command address / write data
//   mem_read_o, mem_write_o           command strobes
//   mem_instr_o                       owner is fetch
//   mem_busy_i, mem_cack_i,
//   mem_ready_i, mem_rdata_i          controller busy, accept, ready, data
// All outputs are registered.
module mem_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned TO_W    = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               f_req_i,
   input  logic [PADDR_W-1:0] f_addr_i,
   output logic               f_ack_o,
   output logic               f_rvalid_o,
   output logic [FDATA_W-1:0] f_rdata_o,
   input  logic               d_req_i,
   input  logic               d_we_i,
   input  logic [PADDR_W-1:0] d_addr_i,
   input  logic [DDATA_W-1:0] d_wdata_i,
   output logic               d_ack_o,
   output logic               d_rvalid_o,
   output logic [DDATA_W-1:0] d_rdata_o,
   output logic               err_o,
   output logic [PADDR_W-1:0] mem_addr_o,
   output logic [DDATA_W-1:0] mem_wdata_o,
   output logic               mem_read_o,
   output logic               mem_write_o,
   output logic               mem_instr_o,
   input  logic               mem_busy_i,
   input  logic               mem_cack_i,
   input  logic               mem_ready_i,
   input  logic [FDATA_W-1:0] mem_rdata_i
);

   // Counter value in the last cycle before the abort fires.
   localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT - 1);

   state_e             state_q, state_d;
   logic               last_q, last_d;
   logic               owner_q, owner_d;
   logic               we_q, we_d;
   logic [TO_W-1:0]    cnt_q, cnt_d;
   logic [PADDR_W-1:0] addr_q, addr_d;
   logic [DDATA_W-1:0] wdata_q, wdata_d;
   logic [FDATA_W-1:0] f_rdata_q, f_rdata_d;
   logic [DDATA_W-1:0] d_rdata_q, d_rdata_d;
   logic               f_ack_q, f_ack_d, d_ack_q, d_ack_d;
   logic               f_rvalid_q, f_rvalid_d, d_rvalid_q, d_rvalid_d;
   logic               err_q, err_d;
   logic               rd_q, rd_d, wr_q, wr_d, instr_q, instr_d;

   logic [1:0]         gnt;
   logic               gnt_valid;
   logic               timeout_hit;
   logic               done_pulse;
   logic               abort;

   arb_rr2 u_arb (
      .req_f_i (f_req_i),
      .req_d_i (d_req_i),
      .last_i  (last_q),
      .gnt_o   (gnt),
      .valid_o (gnt_valid)
   );

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      owner_d     = owner_q;
      we_d        = we_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      f_rdata_d   = f_rdata_q;
      d_rdata_d   = d_rdata_q;
      f_ack_d     = 1'b0;
      d_ack_d     = 1'b0;
      f_rvalid_d  = 1'b0;
      d_rvalid_d  = 1'b0;
      err_d       = 1'b0;
      rd_d        = rd_q;
      wr_d        = wr_q;
      instr_d     = instr_q;
      done_pulse  = 1'b0;
      abort       = 1'b0;
      timeout_hit = (TIMEOUT != 0) && (cnt_q == ToLast);

      unique case (state_q)
         ST_IDLE: begin
            if (gnt_valid && !mem_busy_i) begin
               if (gnt[PORT_D]) begin
                  owner_d = PORT_D;
                  addr_d  = d_addr_i;
                  wdata_d = d_wdata_i;
                  we_d    = d_we_i;
                  d_ack_d = 1'b1;
               end else begin
                  owner_d = PORT_F;
                  addr_d  = f_addr_i;
                  we_d    = 1'b0;
                  f_ack_d = 1'b1;
               end
               rd_d    = !we_d;
               wr_d    = we_d;
               instr_d = (owner_d == PORT_F);
               cnt_d   = '0;
               state_d = ST_CMD;
            end
         end
         ST_CMD: begin
            cnt_d = cnt_q + TO_W'(1);
            if (mem_cack_i) begin
               rd_d = 1'b0;
               wr_d = 1'b0;
               // A read whose data arrives with the accept skips RDW.
               if (we_q || mem_ready_i) begin
                  state_d    = ST_DONE;
                  done_pulse = 1'b1;
               end else begin
                  state_d = ST_RDW;
                  cnt_d   = '0;
               end
            end else if (timeout_hit) begin
               abort = 1'b1;
            end
         end
         ST_RDW: begin
            cnt_d = cnt_q + TO_W'(1);
            if (mem_ready_i) begin
               state_d    = ST_DONE;
               done_pulse = 1'b1;
            end else if (timeout_hit) begin
               abort = 1'b1;
            end
         end
         ST_DONE: begin
            last_d  = owner_q;
            instr_d = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // rvalid is registered so it shows up in DONE together with the data.
      if (done_pulse) begin
         if (owner_q == PORT_F) begin
            f_rvalid_d = 1'b1;
            f_rdata_d  = mem_rdata_i;
         end else begin
            d_rvalid_d = 1'b1;
            if (!we_q) d_rdata_d = mem_rdata_i[DDATA_W-1:0];
         end
      end

      // Abort counts as a served transaction for round-robin fairness.
      if (abort) begin
         err_d   = 1'b1;
         rd_d    = 1'b0;
         wr_d    = 1'b0;
         instr_d = 1'b0;
         last_d  = owner_q;
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         last_q     <= PORT_F;
         owner_q    <= PORT_F;
         we_q       <= 1'b0;
         cnt_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         f_rdata_q  <= '0;
         d_rdata_q  <= '0;
         f_ack_q    <= 1'b0;
         d_ack_q    <= 1'b0;
         f_rvalid_q <= 1'b0;
         d_rvalid_q <= 1'b0;
         err_q      <= 1'b0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         instr_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         owner_q    <= owner_d;
         we_q       <= we_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         f_rdata_q  <= f_rdata_d;
         d_rdata_q  <= d_rdata_d;
         f_ack_q    <= f_ack_d;
         d_ack_q    <= d_ack_d;
         f_rvalid_q <= f_rvalid_d;
         d_rvalid_q <= d_rvalid_d;
         err_q      <= err_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         instr_q    <= instr_d;
      end
   end

   assign f_ack_o     = f_ack_q;
   assign f_rvalid_o  = f_rvalid_q;
   assign f_rdata_o   = f_rdata_q;
   assign d_ack_o     = d_ack_q;
   assign d_rvalid_o  = d_rvalid_q;
   assign d_rdata_o   = d_rdata_q;
   assign err_o       = err_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign mem_read_o  = rd_q;
   assign mem_write_o = wr_q;
   assign mem_instr_o = instr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (TIMEOUT = 4).
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        f_req;
   logic [19:0] f_addr;
   logic        f_ack, f_rvalid;
   logic [31:0] f_rdata;
   logic        d_req, d_we;
   logic [19:0] d_addr;
   logic [15:0] d_wdata;
   logic        d_ack, d_rvalid;
   logic [15:0] d_rdata;
   logic        err;
   logic [19:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_read, mem_write, mem_instr;
   logic        mem_busy, mem_cack, mem_ready;
   logic [31:0] mem_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   mem_arbiter #(
      .TIMEOUT (4),
      .TO_W    (3)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .f_req_i     (f_req),
      .f_addr_i    (f_addr),
      .f_ack_o     (f_ack),
      .f_rvalid_o  (f_rvalid),
      .f_rdata_o   (f_rdata),
      .d_req_i     (d_req),
      .d_we_i      (d_we),
      .d_addr_i    (d_addr),
      .d_wdata_i   (d_wdata),
      .d_ack_o     (d_ack),
      .d_rvalid_o  (d_rvalid),
      .d_rdata_o   (d_rdata),
      .err_o       (err),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_read_o  (mem_read),
      .mem_write_o (mem_write),
      .mem_instr_o (mem_instr),
      .mem_busy_i  (mem_busy),
      .mem_cack_i  (mem_cack),
      .mem_ready_i (mem_ready),
      .mem_rdata_i (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      mem_busy = 1'b0; mem_cack = 1'b0; mem_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Packed output bundle for quiet-state checks.
   function automatic logic [31:0] pulses();
      return {24'd0, f_ack, d_ack, f_rvalid, d_rvalid, err, mem_read, mem_write, mem_instr};
   endfunction

   string grants;
   int    n_gnt;

   initial begin
      f_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
      do_reset();

      // Reset state
      check("reset_pulses", pulses(), 32'h0);
      check("reset_addr", 32'(mem_addr), 32'h0);
      check("reset_wdata", 32'(mem_wdata), 32'h0);
      check("reset_f_rdata", f_rdata, 32'h0);
      check("reset_d_rdata", 32'(d_rdata), 32'h0);

      // Single fetch, best case
      f_req = 1'b1; f_addr = 20'h12340;
      tick();
      check("fetch_ack", 32'(f_ack), 32'h1);
      check("fetch_d_ack", 32'(d_ack), 32'h0);
      check("fetch_read", 32'(mem_read), 32'h1);
      check("fetch_instr", 32'(mem_instr), 32'h1);
      check("fetch_addr", 32'(mem_addr), 32'h12340);
      f_req = 1'b0;
      mem_cack = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
      tick();
      mem_cack = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h0;
      check("fetch_rvalid", 32'(f_rvalid), 32'h1);
      check("fetch_rdata", f_rdata, 32'hDEADBEEF);
      check("fetch_read_drop", 32'(mem_read), 32'h0);
      check("fetch_ack_pulse", 32'(f_ack), 32'h0);
      tick();
      check("fetch_rvalid_pulse", 32'(f_rvalid), 32'h0);
      check("fetch_rdata_hold", f_rdata, 32'hDEADBEEF);

      // Data write, cack on the fourth strobe cycle
      d_req = 1'b1; d_we = 1'b1; d_addr = 20'h00100; d_wdata = 16'hA5A5;
      tick();
      check("wr_ack", 32'(d_ack), 32'h1);
      check("wr_wdata", 32'(mem_wdata), 32'hA5A5);
      check("wr_addr", 32'(mem_addr), 32'h00100);
      check("wr_instr", 32'(mem_instr), 32'h0);
      d_req = 1'b0; d_we = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("wr_strobe_%0d", i), 32'(mem_write), 32'h1);
         check($sformatf("wr_noread_%0d", i), 32'(mem_read), 32'h0);
         if (i == 3) mem_cack = 1'b1;
         tick();
      end
      mem_cack = 1'b0;
      check("wr_strobe_drop", 32'(mem_write), 32'h0);
      check("wr_rvalid", 32'(d_rvalid), 32'h1);
      check("wr_no_err", 32'(err), 32'h0);
      check("wr_d_rdata_kept", 32'(d_rdata), 32'h0);
      tick();
      check("wr_rvalid_pulse", 32'(d_rvalid), 32'h0);

      // Contention: both requests held, 4 transactions from reset
      do_reset();
      f_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
      f_addr = 20'h0F000; d_addr = 20'h0D000; mem_rdata = 32'hCAFE1234;
      grants = "";
      n_gnt = 0;
      for (int c = 0; c < 16; c++) begin
         tick();
         if (f_ack && d_ack) check("cont_both_ack", 32'h1, 32'h0);
         if (f_rvalid && d_rvalid) check("cont_both_rvalid", 32'h1, 32'h0);
         if (d_ack) begin grants = {grants, "D"}; n_gnt++; end
         if (f_ack) begin grants = {grants, "F"}; n_gnt++; end
         if (n_gnt >= 4) begin f_req = 1'b0; d_req = 1'b0; end
         // Simple responder: accept and return data with the strobe.
         mem_cack  = mem_read | mem_write;
         mem_ready = mem_read;
      end
      mem_cack = 1'b0; mem_ready = 1'b0;
      check("cont_count", 32'(n_gnt), 32'd4);
      check("cont_order", (grants == "DFDF") ? 32'h1 : 32'h0, 32'h1);
      if (grants != "DFDF") $display("  grant order seen: %s", grants);
      check("cont_f_rdata", f_rdata, 32'hCAFE1234);
      check("cont_d_rdata", 32'(d_rdata), 32'h1234);

      // Busy hold-off
      mem_busy = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 20'h55555;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("busy_quiet_%0d", i), pulses(), 32'h0);
      end
      mem_busy = 1'b0;
      tick();
      check("busy_ack", 32'(d_ack), 32'h1);
      check("busy_read", 32'(mem_read), 32'h1);
      check("busy_addr", 32'(mem_addr), 32'h55555);
      d_req = 1'b0;
      mem_cack = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h0000BEEF;
      tick();
      mem_cack = 1'b0; mem_ready = 1'b0;
      check("busy_rvalid", 32'(d_rvalid), 32'h1);
      check("busy_rdata", 32'(d_rdata), 32'hBEEF);
      tick();

      // Timeout in RDW
      f_req = 1'b1; f_addr = 20'h0ABCD;
      tick();
      check("to_ack", 32'(f_ack), 32'h1);
      f_req = 1'b0;
      mem_cack = 1'b1;
      tick();
      mem_cack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("to_wait_err_%0d", i), 32'(err), 32'h0);
         check($sformatf("to_wait_rvalid_%0d", i), 32'(f_rvalid), 32'h0);
         check($sformatf("to_wait_read_%0d", i), 32'(mem_read), 32'h0);
         tick();
      end
      check("to_err", 32'(err), 32'h1);
      check("to_no_rvalid", 32'(f_rvalid), 32'h0);
      check("to_instr_drop", 32'(mem_instr), 32'h0);
      check("to_rdata_kept", f_rdata, 32'hCAFE1234);
      tick();
      check("to_err_pulse", 32'(err), 32'h0);
      // Aborted fetch counts as served, so data wins the next tie.
      f_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
      tick();
      check("to_next_d_ack", 32'(d_ack), 32'h1);
      check("to_next_f_ack", 32'(f_ack), 32'h0);
      f_req = 1'b0; d_req = 1'b0;
      mem_cack = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h00002468;
      tick();
      mem_cack = 1'b0; mem_ready = 1'b0;
      check("to_next_rvalid", 32'(d_rvalid), 32'h1);
      check("to_next_rdata", 32'(d_rdata), 32'h2468);
      tick();

      // Reset mid-read
      do_reset();
      d_req = 1'b1; d_we = 1'b0; d_addr = 20'h00777;
      tick();
      check("rst_ack", 32'(d_ack), 32'h1);
      d_req = 1'b0;
      mem_cack = 1'b1;
      tick();
      mem_cack = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_quiet", pulses(), 32'h0);
      check("rst_addr", 32'(mem_addr), 32'h0);
      mem_ready = 1'b1; mem_rdata = 32'h00009999;
      tick();
      mem_ready = 1'b0;
      check("rst_late_ready", pulses(), 32'h0);
      check("rst_late_rdata", 32'(d_rdata), 32'h0);
      tick();
      check("rst_late_ready2", pulses(), 32'h0);
      // Arbiter is idle again and serves a new fetch.
      f_req = 1'b1; f_addr = 20'h00042;
      tick();
      check("rst_next_ack", 32'(f_ack), 32'h1);
      f_req = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
